// File: rtl/circle_ptn_gen.sv
// circle_ptn_gen: rotating one-hot LED pattern with a 4-bit position index.
// Starts from IDLE on start, steps every TICK_DIV clocks in RUN, and freezes
// in DONE on run_stop until reset.
module circle_ptn_gen #(
  parameter int unsigned CNT_LENGTH = 8,
  parameter int unsigned TICK_DIV   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  dir,
  input  logic                  run_stop,
  output logic [3:0]            ptn_cnt,
  output logic [CNT_LENGTH-1:0] led,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [3:0]            PTN_LAST = 4'(CNT_LENGTH - 1);
  localparam logic [CNT_LENGTH-1:0] LED_ONE  = CNT_LENGTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic [DIV_W-1:0]      r_div_cnt;

  state_t                w_state_nxt;
  logic [DIV_W-1:0]      w_div_nxt;
  logic [3:0]            w_ptn_nxt;
  logic [CNT_LENGTH-1:0] w_led_nxt;
  logic                  w_busy_nxt;
  logic                  w_done_nxt;

  // Next-state and next-output decode; everything holds unless a state acts.
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div_cnt;
    w_ptn_nxt   = ptn_cnt;
    w_led_nxt   = led;
    w_busy_nxt  = busy;
    w_done_nxt  = done;
    case (r_state)
      ST_IDLE: begin
        w_led_nxt  = '0;
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        if (start) begin
          w_state_nxt = ST_RUN;
          w_ptn_nxt   = 4'd0;
          w_led_nxt   = LED_ONE;
          w_busy_nxt  = 1'b1;
          w_div_nxt   = '0;
        end
      end
      ST_RUN: begin
        if (run_stop) begin
          // Stop wins over a coincident step: index, LEDs and divider freeze.
          w_state_nxt = ST_DONE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else begin
          if (r_div_cnt == DIV_LAST) begin
            w_div_nxt = '0;
            if (!dir) begin
              w_ptn_nxt = (ptn_cnt == PTN_LAST) ? 4'd0 : ptn_cnt + 4'd1;
            end else begin
              w_ptn_nxt = (ptn_cnt == 4'd0) ? PTN_LAST : ptn_cnt - 4'd1;
            end
          end else begin
            w_div_nxt = r_div_cnt + DIV_W'(1);
          end
          w_led_nxt = LED_ONE << w_ptn_nxt;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_DONE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_ptn_nxt   = 4'd0;
        w_led_nxt   = '0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_div_nxt   = '0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_div_cnt <= '0;
      ptn_cnt   <= 4'd0;
      led       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_div_cnt <= w_div_nxt;
      ptn_cnt   <= w_ptn_nxt;
      led       <= w_led_nxt;
      busy      <= w_busy_nxt;
      done      <= w_done_nxt;
    end
  end

endmodule

// File: tb/tb_circle_ptn_gen.sv
// tb_circle_ptn_gen: directed checks of circle_ptn_gen with TICK_DIV=1 and 3,
// plus a closed loop against a small lap counter.
module tb_circle_ptn_gen;

  logic       clk;
  logic       rst;
  logic       start;
  logic       dir;
  logic       rs1;
  logic       rs3;
  logic       use_lap;
  logic       run_stop1;
  logic [3:0] p1, p3;
  logic [7:0] led1, led3;
  logic       busy1, busy3, done1, done3;
  logic [2:0] lap;
  logic       lap_stop;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] up_ptn [9] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd0, 4'd1};
  logic [7:0] up_led [9] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
  logic [3:0] dn_ptn [3] = '{4'd7, 4'd6, 4'd5};
  logic [7:0] dn_led [3] = '{8'h80, 8'h40, 8'h20};

  circle_ptn_gen #(.CNT_LENGTH(8), .TICK_DIV(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .run_stop(run_stop1),
    .ptn_cnt(p1), .led(led1), .busy(busy1), .done(done1)
  );

  circle_ptn_gen #(.CNT_LENGTH(8), .TICK_DIV(3)) u_d3 (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .run_stop(rs3),
    .ptn_cnt(p3), .led(led3), .busy(busy3), .done(done3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lap counter stand-in: counts edges with index 7, stops after 7 of them.
  always @(posedge clk) begin
    if (!rst) lap <= 3'd0;
    else if (use_lap && p1 == 4'd7 && lap != 3'd7) lap <= lap + 3'd1;
  end
  assign lap_stop  = (lap == 3'd7);
  assign run_stop1 = use_lap ? lap_stop : rs1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_d1(input string tag, input logic [3:0] ep, input logic [7:0] el,
                        input logic eb, input logic ed);
    chk({tag, "_ptn"},  32'(p1),    32'(ep));
    chk({tag, "_led"},  32'(led1),  32'(el));
    chk({tag, "_busy"}, 32'(busy1), 32'(eb));
    chk({tag, "_done"}, 32'(done1), 32'(ed));
  endtask

  initial begin
    int first_done;
    rst = 1'b0; start = 1'b1; dir = 1'b0; rs1 = 1'b0; rs3 = 1'b0; use_lap = 1'b0;

    // Reset beats start
    tick(); tick();
    chk_d1("rst", 4'd0, 8'h00, 1'b0, 1'b0);
    chk("rst_d3_busy", 32'(busy3), 32'd0);

    // Count up, both dividers started together
    rst = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk_d1("up_start", 4'd0, 8'h01, 1'b1, 1'b0);
    chk("div3_k0", 32'(p3), 32'd0);
    for (int k = 1; k <= 26; k++) begin
      tick();
      if (k <= 9) begin
        chk("up_ptn", 32'(p1), 32'(up_ptn[k-1]));
        chk("up_led", 32'(led1), 32'(up_led[k-1]));
      end
      chk("div3_ptn", 32'(p3), 32'((k / 3) % 8));
    end
    chk("div3_wrap_busy", 32'(busy3), 32'd1);

    // Count down, then stop at index 5
    rst = 1'b0; tick();
    rst = 1'b1; start = 1'b1; dir = 1'b1;
    tick();
    start = 1'b0;
    chk_d1("dn_start", 4'd0, 8'h01, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("dn_ptn", 32'(p1), 32'(dn_ptn[k]));
      chk("dn_led", 32'(led1), 32'(dn_led[k]));
    end
    rs1 = 1'b1;
    tick();
    chk_d1("stop", 4'd5, 8'h20, 1'b0, 1'b1);
    rs1 = 1'b0; start = 1'b1; dir = 1'b0;
    tick();
    start = 1'b0; dir = 1'b1;
    tick();
    chk_d1("done_hold", 4'd5, 8'h20, 1'b0, 1'b1);

    // Reset mid-run, restart, mid-lap direction change
    rst = 1'b0; tick();
    rst = 1'b1; start = 1'b1; dir = 1'b0;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("mid_ptn3", 32'(p1), 32'd3);
    rst = 1'b0;
    tick();
    chk_d1("mid_rst", 4'd0, 8'h00, 1'b0, 1'b0);
    rst = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk_d1("restart", 4'd0, 8'h01, 1'b1, 1'b0);
    tick();
    chk("restart_step", 32'(p1), 32'd1);
    dir = 1'b1;
    tick();
    chk("dirflip_1", 32'(p1), 32'd0);
    tick();
    chk("dirflip_2", 32'(p1), 32'd7);
    chk("dirflip_led", 32'(led1), 32'h80);

    // Closed loop with the lap counter
    rst = 1'b0; dir = 1'b0; use_lap = 1'b1;
    tick();
    rst = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    first_done = -1;
    for (int k = 1; k <= 70; k++) begin
      tick();
      if (k == 56) chk("lap_busy56", 32'(busy1), 32'd1);
      if (done1 && first_done < 0) begin
        first_done = k;
        chk("lap_ptn_frozen", 32'(p1), 32'd0);
      end
    end
    chk("lap_done_edge", 32'(first_done), 32'd57);
    chk("lap_done_hold", 32'(done1), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
